// File: rtl/seqgen_ctrl.sv
// Command controller for a bank of 1-bit sequence players: serialises LOAD bytes
// into per-bit player writes, tracks per-channel lengths and issues start/stop pulses.
module seqgen_len_lane #(
  parameter int unsigned AW = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] len
);
  always_ff @(posedge clk) begin
    if (rst)      len <= '0;
    else if (clr) len <= '0;
    else if (inc) len <= len + (AW+1)'(8);
  end
endmodule

module seqgen_ctrl #(
  parameter int unsigned NCH = 4,
  parameter int unsigned AW  = 8,
  parameter int unsigned CW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [CW-1:0]         cmd_ch,
  input  logic [7:0]            cmd_data,
  input  logic                  err_clr,
  input  logic [NCH-1:0]        ch_playing,
  output logic [NCH-1:0]        ch_wr_en,
  output logic [AW-1:0]         ch_wr_addr,
  output logic                  ch_wr_bit,
  output logic [NCH-1:0]        ch_start,
  output logic [NCH-1:0]        ch_stop,
  output logic [NCH*(AW+1)-1:0] ch_len,
  output logic                  busy,
  output logic                  err_sticky
);
  typedef enum logic [1:0] {IDLE, SHIFT, PULSE} state_t;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_START = 2'd1, OP_STOP = 2'd2;
  // Highest write pointer that still leaves room for a whole byte.
  localparam logic [AW:0] LD_MAX = (AW+1)'((1 << AW) - 8);

  state_t state, state_nx;
  logic [NCH-1:0][AW:0] len_q;
  logic [NCH-1:0] sel_oh, nz, mask, eff, sh_oh, lane_clr, lane_inc;
  logic [AW:0]    sel_len;
  logic [7:0]     byte_q;
  logic [2:0]     k;
  logic sel_play, ch_ok, ld_go, err_set, acc;

  assign acc       = cmd_valid && (state == IDLE);
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mask      = cmd_data[NCH-1:0];
  assign eff       = mask & ~ch_playing & nz;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_lane
      seqgen_len_lane #(.AW(AW)) u_lane (
        .clk (clk),
        .rst (rst),
        .clr (lane_clr[gi]),
        .inc (lane_inc[gi]),
        .len (len_q[gi])
      );
      assign nz[gi] = (len_q[gi] != '0);
      assign ch_len[gi*(AW+1) +: AW+1] = len_q[gi];
    end
  endgenerate

  // Channel decode; an out-of-range cmd_ch leaves sel_oh empty and ch_ok low.
  always_comb begin
    sel_oh = '0; sel_play = 1'b0; sel_len = '0; ch_ok = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (cmd_ch == CW'(i)) begin
        sel_oh[i] = 1'b1;
        sel_play  = ch_playing[i];
        sel_len   = len_q[i];
        ch_ok     = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    ld_go    = 1'b0;
    lane_clr = '0;
    lane_inc = '0;
    case (state)
      IDLE: if (cmd_valid) begin
        case (cmd_op)
          OP_LOAD: begin
            if (!ch_ok || sel_play || sel_len > LD_MAX) err_set = 1'b1;
            else begin
              ld_go    = 1'b1;
              state_nx = SHIFT;
            end
          end
          OP_START: begin
            state_nx = PULSE;
            err_set  = |(mask & ~nz);
          end
          OP_STOP: state_nx = PULSE;
          default: begin
            if (!ch_ok || sel_play) err_set = 1'b1;
            else lane_clr = sel_oh;
          end
        endcase
      end
      SHIFT: if (k == 3'd7) begin
        state_nx = IDLE;
        lane_inc = sh_oh;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      byte_q     <= '0;
      sh_oh      <= '0;
      ch_wr_en   <= '0;
      ch_wr_addr <= '0;
      ch_wr_bit  <= 1'b0;
      ch_start   <= '0;
      ch_stop    <= '0;
      err_sticky <= 1'b0;
    end else begin
      state    <= state_nx;
      ch_start <= '0;
      ch_stop  <= '0;
      if (err_set)      err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
      if (ld_go) begin
        byte_q     <= cmd_data;
        sh_oh      <= sel_oh;
        k          <= '0;
        ch_wr_en   <= sel_oh;
        ch_wr_addr <= sel_len[AW-1:0];
        ch_wr_bit  <= cmd_data[0];
      end else if (state == SHIFT) begin
        if (k == 3'd7) ch_wr_en <= '0;
        else begin
          k          <= k + 3'd1;
          ch_wr_addr <= ch_wr_addr + AW'(1);
          ch_wr_bit  <= byte_q[k + 3'd1];
        end
      end
      if (acc && cmd_op == OP_START) ch_start <= eff;
      if (acc && cmd_op == OP_STOP)  ch_stop  <= mask;
    end
  end
endmodule

// File: tb/tb_seqgen_ctrl.sv
// Directed bench for seqgen_ctrl (NCH=4, AW=8): loads, start/stop, clear,
// length saturation, error flag handling and reset mid-load.
module tb_seqgen_ctrl;
  localparam int NCH = 4, AW = 8, CW = 2;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_START = 2'd1, OP_STOP = 2'd2, OP_CLEAR = 2'd3;

  logic clk = 1'b0;
  logic rst, cmd_valid, cmd_ready, err_clr, ch_wr_bit, busy, err_sticky;
  logic [1:0] cmd_op;
  logic [CW-1:0] cmd_ch;
  logic [7:0] cmd_data;
  logic [NCH-1:0] ch_playing, ch_wr_en, ch_start, ch_stop;
  logic [AW-1:0] ch_wr_addr;
  logic [NCH*(AW+1)-1:0] ch_len;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  seqgen_ctrl #(.NCH(NCH), .AW(AW), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ch(cmd_ch), .cmd_data(cmd_data), .err_clr(err_clr),
    .ch_playing(ch_playing), .ch_wr_en(ch_wr_en), .ch_wr_addr(ch_wr_addr),
    .ch_wr_bit(ch_wr_bit), .ch_start(ch_start), .ch_stop(ch_stop),
    .ch_len(ch_len), .busy(busy), .err_sticky(err_sticky)
  );

  function automatic logic [AW:0] getlen(input int i);
    return ch_len[i*(AW+1) +: AW+1];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [1:0] op, input int ch, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_ch = CW'(ch); cmd_data = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_load(input int ch, input logic [7:0] d, input int base, input int exp_len);
    issue(OP_LOAD, ch, d);
    for (int k = 0; k < 8; k++) begin
      chk("wr_en", ch_wr_en, 4'b0001 << ch);
      chk("wr_addr", ch_wr_addr, base + k);
      chk("wr_bit", ch_wr_bit, d[k]);
      chk("ready_low", cmd_ready, 0);
      step();
    end
    chk("ready_after", cmd_ready, 1);
    chk("wr_en_after", ch_wr_en, 0);
    chk("len_after", getlen(ch), exp_len);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ch = '0; cmd_data = '0;
    err_clr = 1'b0; ch_playing = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_wr_en", ch_wr_en, 0);
    chk("rst_len", ch_len, 0);

    // Back-to-back loads on ch2: 0xA5 (bits 1,0,1,0,0,1,0,1) then 0x3C.
    do_load(2, 8'hA5, 0, 8);
    do_load(2, 8'h3C, 8, 16);
    chk("load_err", err_sticky, 0);

    // START 0x05: ch0 empty -> error, ch2 starts.
    issue(OP_START, 0, 8'h05);
    chk("start_pulse", ch_start, 4'b0100);
    chk("start_err", err_sticky, 1);
    chk("start_busy", busy, 1);
    step();
    chk("start_pulse_end", ch_start, 0);
    chk("start_ready", cmd_ready, 1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("err_clr", err_sticky, 0);

    // Load to a playing channel is rejected.
    ch_playing = 4'b0100;
    issue(OP_LOAD, 2, 8'hFF);
    chk("play_rej_wr_en", ch_wr_en, 0);
    chk("play_rej_ready", cmd_ready, 1);
    chk("play_rej_err", err_sticky, 1);
    chk("play_rej_len", getlen(2), 16);
    err_clr = 1'b1; step(); err_clr = 1'b0;

    // START on an already playing channel is silently skipped.
    issue(OP_START, 0, 8'h04);
    chk("skip_start", ch_start, 0);
    chk("skip_err", err_sticky, 0);
    step();
    issue(OP_STOP, 0, 8'hFF);
    chk("stop_pulse", ch_stop, 4'b1111);
    chk("stop_no_start", ch_start, 0);
    step();
    chk("stop_pulse_end", ch_stop, 0);

    // CLEAR ch2, then reload from address 0.
    ch_playing = '0;
    issue(OP_CLEAR, 2, 8'h00);
    chk("clear_len", getlen(2), 0);
    chk("clear_ready", cmd_ready, 1);
    chk("clear_busy", busy, 0);
    do_load(2, 8'h81, 0, 8);

    // Fill ch3 to 256 bits; next load is rejected.
    for (int i = 0; i < 32; i++) do_load(3, 8'(i * 7 + 1), i * 8, i * 8 + 8);
    chk("full_len", getlen(3), 256);
    err_clr = 1'b1;
    issue(OP_LOAD, 3, 8'h55);
    err_clr = 1'b0;
    chk("full_rej_err_set_wins", err_sticky, 1);
    chk("full_rej_wr_en", ch_wr_en, 0);
    chk("full_rej_len", getlen(3), 256);

    // Reset during T4 of a load.
    issue(OP_LOAD, 1, 8'hFF);
    step(); step(); step();
    chk("pre_rst_wr_en", ch_wr_en, 4'b0010);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_wr_en", ch_wr_en, 0);
    chk("mid_rst_len", ch_len, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_sticky, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
